// File: rtl/mpx_bus_pkg.sv
// Shared types and constants for the MPX bus target: TT codes, FSM encoding, geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mpx_bus_pkg;

    localparam int BURST_LEN = 4;
    localparam int MEM_DEPTH = 16;
    localparam int IDX_W     = $clog2(MEM_DEPTH);

    localparam logic [0:4] TT_WRITE   = 5'b00010;
    localparam logic [0:4] TT_WRITE_K = 5'b00110;
    localparam logic [0:4] TT_READ    = 5'b01010;
    localparam logic [0:4] TT_READ_K  = 5'b01110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_AACK  = 3'd2,
`ifdef MPX_ARTRY_EN
        ST_RETRY = 3'd3,
`endif
        ST_DBG   = 3'd4,
        ST_DATA  = 3'd5
    } state_t;

    function automatic logic tt_is_write(input logic [0:4] tt);
        return (tt == TT_WRITE) || (tt == TT_WRITE_K);
    endfunction

    function automatic logic tt_is_read(input logic [0:4] tt);
        return (tt == TT_READ) || (tt == TT_READ_K);
    endfunction

endpackage

// File: rtl/mpx_bus_if.sv
// MPX 60x-style bus signal bundle; bit 0 is the MSB on every vector.
// Latency: n/a (wiring only).
// Backpressure: n/a; BG/AACK/DBG/TA pace the master.
interface mpx_bus_if;
    logic        BR;
    logic        BG;
    logic        TS;
    logic [0:31] A;
    logic [0:4]  TT;
    logic        TBST;
    logic [0:2]  TSIZ;
    logic        WT;
    logic        AACK;
    logic        ARTRY;
    logic        LOCK;
    logic        DBG;
    logic        TA;
    logic        TEA;
    logic [0:31] DH_IN;
    logic [0:31] DL_IN;
    logic [0:31] DH_OUT;
    logic [0:31] DL_OUT;
    logic        D_OE;

    modport master (
        output BR, TS, A, TT, TBST, TSIZ, WT, LOCK, DH_IN, DL_IN,
        input  BG, AACK, ARTRY, DBG, TA, TEA, DH_OUT, DL_OUT, D_OE
    );

    modport slave (
        input  BR, TS, A, TT, TBST, TSIZ, WT, LOCK, DH_IN, DL_IN,
        output BG, AACK, ARTRY, DBG, TA, TEA, DH_OUT, DL_OUT, D_OE
    );
endinterface

// File: rtl/mpx_mem_array.sv
// 16 x 64-bit single-port doubleword store; contents deliberately have no reset.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none.
module mpx_mem_array
    import mpx_bus_pkg::*;
(
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdat,
    output logic [63:0]      rdat
);
    logic [63:0] mem [MEM_DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdat;
        end
    end

    assign rdat = mem[idx];
endmodule

// File: rtl/mpx_bus_target.sv
// MPX bus target: arbitration, address tenure, 1/4-beat data tenure over a 16x64 memory; MPX_ARTRY_EN adds LOCK-driven ARTRY.
// Latency: BR->BG 1 cycle, TS->AACK 1 cycle, AACK->DBG 1 cycle, then TA per beat.
// Backpressure: single outstanding transaction; BR/TS outside their window wait or are ignored.
module mpx_bus_target
    import mpx_bus_pkg::*;
#(
    parameter logic [0:23] BASE_ADDR = 24'hAAAAAA
) (
    input  logic     CLK,
    input  logic     RST,
    mpx_bus_if.slave bus
);
    state_t      state_q, state_d;
    logic [0:31] a_q;
    logic [0:4]  tt_q;
    logic        tbst_q;
    logic [0:2]  tsiz_q;
    logic [1:0]  beat_q;
    logic        latch_en;

    logic        is_wr, is_rd, in_range, last_beat;
    logic        in_data, mem_we;
    logic [3:0]  base_idx, cur_idx;
    logic [63:0] mem_rdat;

    assign is_wr     = tt_is_write(tt_q);
    assign is_rd     = tt_is_read(tt_q);
    assign in_range  = (a_q[0:23] == BASE_ADDR);
    assign last_beat = tbst_q || (beat_q == 2'(BURST_LEN - 1));
    assign base_idx  = a_q[25:28];
    // Critical-doubleword-first: low two index bits wrap, the upper pair stays put.
    assign cur_idx   = {base_idx[3:2], 2'(base_idx[1:0] + beat_q)};
    assign in_data   = (state_q == ST_DATA);
    assign mem_we    = in_data && in_range && is_wr;

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        bus.BG     = 1'b1;
        bus.AACK   = 1'b1;
        bus.ARTRY  = 1'b1;
        bus.DBG    = 1'b1;
        bus.TA     = 1'b1;
        bus.TEA    = 1'b1;
        bus.D_OE   = 1'b0;
        bus.DH_OUT = '0;
        bus.DL_OUT = '0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.BR) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                bus.BG = 1'b0;
                if (!bus.TS) begin
                    latch_en = 1'b1;
                    state_d  = ST_AACK;
                end
            end
            ST_AACK: begin
                bus.AACK = 1'b0;
                state_d  = (is_wr || is_rd) ? ST_DBG : ST_IDLE;
`ifdef MPX_ARTRY_EN
                if (bus.LOCK) state_d = ST_RETRY;
`endif
            end
`ifdef MPX_ARTRY_EN
            ST_RETRY: begin
                bus.ARTRY = 1'b0;
                state_d   = ST_IDLE;
            end
`endif
            ST_DBG: begin
                bus.DBG = 1'b0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                // Out-of-range address: one TEA replaces the whole data tenure.
                if (!in_range) begin
                    bus.TEA = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    bus.TA = 1'b0;
                    if (is_rd) begin
                        bus.D_OE   = 1'b1;
                        bus.DH_OUT = mem_rdat[63:32];
                        bus.DL_OUT = mem_rdat[31:0];
                    end
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            tt_q    <= '0;
            tbst_q  <= 1'b0;
            tsiz_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                a_q    <= bus.A;
                tt_q   <= bus.TT;
                tbst_q <= bus.TBST;
                tsiz_q <= bus.TSIZ;
            end
            beat_q <= in_data ? 2'(beat_q + 2'd1) : 2'd0;
        end
    end

    mpx_mem_array u_mem (
        .CLK  (CLK),
        .we   (mem_we),
        .idx  (cur_idx),
        .wdat ({bus.DH_IN, bus.DL_IN}),
        .rdat (mem_rdat)
    );

    // TSIZ is kept for visibility only; WT and the sub-doubleword address bits have no effect.
    logic unused_sink;
`ifdef MPX_ARTRY_EN
    assign unused_sink = ^{bus.WT, tsiz_q, a_q[24], a_q[29:31]};
`else
    assign unused_sink = ^{bus.WT, bus.LOCK, tsiz_q, a_q[24], a_q[29:31]};
`endif
endmodule

// File: tb/tb_mpx_bus_target.sv
// Bench for mpx_bus_target: directed vector table, hand-written corner sequences, randomized traffic vs a memory model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mpx_bus_target;
    logic CLK = 1'b0;
    logic RST;

    mpx_bus_if bus();

    mpx_bus_target #(.BASE_ADDR(24'hAAAAAA)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

`ifdef MPX_ARTRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mdl   [16];
    bit          known [16];

    typedef struct {
        logic [31:0]       addr;
        logic [4:0]        tt;
        logic              tbst;
        logic              lock;
        logic [3:0][63:0]  wd;
        int                e_ta;
        int                e_tea;
        int                e_doe;
        int                e_dbg;
        int                e_artry;
        logic [3:0][63:0]  e_rd;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [4:0] tt, input logic tbst,
                                input logic lock, input logic [3:0][63:0] wd, input int e_ta,
                                input int e_tea, input int e_doe, input int e_dbg, input int e_artry,
                                input logic [3:0][63:0] e_rd);
        vec_t v;
        v.addr = addr; v.tt = tt; v.tbst = tbst; v.lock = lock; v.wd = wd;
        v.e_ta = e_ta; v.e_tea = e_tea; v.e_doe = e_doe; v.e_dbg = e_dbg;
        v.e_artry = e_artry; v.e_rd = e_rd;
        return v;
    endfunction

    // Doubleword index of beat b: address bits 6:3, low pair wrapping mod 4.
    function automatic int idx_of(input logic [31:0] addr, input int b);
        int base;
        base = int'((addr >> 3) & 32'hF);
        return (base & 12) | ((base + b) % 4);
    endfunction

    function automatic bit tt_wr(input logic [4:0] tt);
        return (tt == 5'd2) || (tt == 5'd6);
    endfunction

    function automatic bit tt_rd(input logic [4:0] tt);
        return (tt == 5'd10) || (tt == 5'd14);
    endfunction

    task automatic model_commit(input logic [31:0] addr, input logic [4:0] tt, input logic tbst,
                                input logic lock, input logic [3:0][63:0] wd);
        int beats;
        beats = tbst ? 1 : 4;
        if (tt_wr(tt) && addr[31:8] == 24'hAAAAAA && !(RETRY_EN && lock)) begin
            for (int b = 0; b < beats; b++) begin
                mdl[idx_of(addr, b)]   = wd[b];
                known[idx_of(addr, b)] = 1'b1;
            end
        end
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (bus.BG !== 1'b0 && lat < 20);
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [4:0] tt, input logic tbst,
                           input logic lock, input logic [3:0][63:0] wd,
                           output int bg_lat, output int aack_n, output int artry_n,
                           output int dbg_at, output int ta_n, output int ta_at,
                           output int tea_n, output int doe_n, output logic [3:0][63:0] rd);
        int beat;
        aack_n = 0; artry_n = 0; dbg_at = -1; ta_n = 0; ta_at = -1;
        tea_n = 0; doe_n = 0; rd = '0; beat = 0;
        bus.BR = 1'b0;
        wait_grant(bg_lat);
        bus.BR   = 1'b1;
        bus.TS   = 1'b0;
        bus.A    = addr;
        bus.TT   = tt;
        bus.TBST = tbst;
        bus.TSIZ = 3'($urandom);
        bus.WT   = 1'($urandom);
        bus.LOCK = lock;
        @(negedge CLK);
        bus.TS = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge CLK);
            if (bus.AACK == 1'b0) aack_n++;
            if (bus.ARTRY == 1'b0) artry_n++;
            if (bus.DBG == 1'b0 && dbg_at < 0) dbg_at = c;
            if (bus.TEA == 1'b0) tea_n++;
            if (bus.D_OE == 1'b1) doe_n++;
            if (bus.TA == 1'b0) begin
                if (ta_at < 0) ta_at = c;
                if (beat < 4) begin
                    rd[beat]  = {bus.DH_OUT, bus.DL_OUT};
                    bus.DH_IN = wd[beat][63:32];
                    bus.DL_IN = wd[beat][31:0];
                end
                beat++;
                ta_n++;
            end
        end
        bus.LOCK  = 1'b0;
        bus.DH_IN = '0;
        bus.DL_IN = '0;
    endtask

    task automatic chk_common(input string tag, input int bg_lat, input int aack_n,
                              input int ta_n, input int ta_at);
        chk({tag, "_bg_lat"}, 64'(bg_lat), 64'(1));
        chk({tag, "_aack"}, 64'(aack_n), 64'(1));
        if (ta_n > 0) chk({tag, "_ta_at"}, 64'(ta_at), 64'(2));
    endtask

    initial begin
        int bg_lat, aack_n, artry_n, dbg_at, ta_n, ta_at, tea_n, doe_n, lat;
        logic [3:0][63:0] rd;

        for (int i = 0; i < 16; i++) begin
            known[i] = 1'b0;
            mdl[i]   = '0;
        end
        RST = 1'b1;
        bus.BR = 1'b1; bus.TS = 1'b1; bus.A = '0; bus.TT = '0; bus.TBST = 1'b1;
        bus.TSIZ = '0; bus.WT = 1'b0; bus.LOCK = 1'b0; bus.DH_IN = '0; bus.DL_IN = '0;

        vt[0] = mk(32'hAAAAAA08, 5'b00010, 1'b1, 1'b0, {192'd0, 64'hAA00000000000000}, 1, 0, 0, 1, 0, '0);
        vt[1] = mk(32'hAAAAAA08, 5'b01010, 1'b1, 1'b0, '0, 1, 0, 1, 1, 0, {192'd0, 64'hAA00000000000000});
        vt[2] = mk(32'hAAAAAA20, 5'b00110, 1'b0, 1'b0, {64'd4, 64'd3, 64'd2, 64'd1}, 4, 0, 0, 1, 0, '0);
        vt[3] = mk(32'hAAAAAA30, 5'b01110, 1'b0, 1'b0, '0, 4, 0, 4, 1, 0, {64'd2, 64'd1, 64'd4, 64'd3});
        vt[4] = mk(32'h12345608, 5'b00010, 1'b1, 1'b0, {192'd0, 64'hFFFFFFFFFFFFFFFF}, 0, 1, 0, 1, 0, '0);
        vt[5] = mk(32'hAAAAAA08, 5'b01010, 1'b1, 1'b0, '0, 1, 0, 1, 1, 0, {192'd0, 64'hAA00000000000000});
        vt[6] = mk(32'hAAAAAA08, 5'b00000, 1'b1, 1'b0, '0, 0, 0, 0, -1, 0, '0);
        vt[7] = mk(32'h12345630, 5'b01110, 1'b0, 1'b0, '0, 0, 1, 0, 1, 0, '0);
`ifdef MPX_ARTRY_EN
        vt[8] = mk(32'hAAAAAA08, 5'b00010, 1'b1, 1'b1, {192'd0, 64'h5555}, 0, 0, 0, -1, 1, '0);
        vt[9] = mk(32'hAAAAAA08, 5'b01010, 1'b1, 1'b0, '0, 1, 0, 1, 1, 0, {192'd0, 64'hAA00000000000000});
`else
        vt[8] = mk(32'hAAAAAA08, 5'b00010, 1'b1, 1'b1, {192'd0, 64'h5555}, 1, 0, 0, 1, 0, '0);
        vt[9] = mk(32'hAAAAAA08, 5'b01010, 1'b1, 1'b0, '0, 1, 0, 1, 1, 0, {192'd0, 64'h5555});
`endif

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_bg", 64'(bus.BG), 64'(1));
        chk("rst_aack", 64'(bus.AACK), 64'(1));
        chk("rst_artry", 64'(bus.ARTRY), 64'(1));
        chk("rst_dbg", 64'(bus.DBG), 64'(1));
        chk("rst_ta", 64'(bus.TA), 64'(1));
        chk("rst_tea", 64'(bus.TEA), 64'(1));
        chk("rst_doe", 64'(bus.D_OE), 64'(0));
        RST = 1'b0;
        @(negedge CLK);

        // TS with no grant must be ignored
        bus.TS = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("ts_ignored_aack", 64'(bus.AACK), 64'(1));
            chk("ts_ignored_bg", 64'(bus.BG), 64'(1));
        end
        bus.TS = 1'b1;
        @(negedge CLK);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].addr, vt[i].tt, vt[i].tbst, vt[i].lock, vt[i].wd,
                    bg_lat, aack_n, artry_n, dbg_at, ta_n, ta_at, tea_n, doe_n, rd);
            chk_common($sformatf("vec%0d", i), bg_lat, aack_n, ta_n, ta_at);
            chk($sformatf("vec%0d_ta", i), 64'(ta_n), 64'(vt[i].e_ta));
            chk($sformatf("vec%0d_tea", i), 64'(tea_n), 64'(vt[i].e_tea));
            chk($sformatf("vec%0d_doe", i), 64'(doe_n), 64'(vt[i].e_doe));
            chk($sformatf("vec%0d_dbg_at", i), 64'(dbg_at), 64'(vt[i].e_dbg));
            chk($sformatf("vec%0d_artry", i), 64'(artry_n), 64'(vt[i].e_artry));
            for (int b = 0; b < vt[i].e_doe; b++)
                chk($sformatf("vec%0d_rd%0d", i, b), rd[b], vt[i].e_rd[b]);
            model_commit(vt[i].addr, vt[i].tt, vt[i].tbst, vt[i].lock, vt[i].wd);
        end

        // BR held low across a transaction: granted again one cycle after the idle cycle
        bus.BR = 1'b0;
        wait_grant(lat);
        chk("b2b_first_grant", 64'(lat), 64'(1));
        bus.TS = 1'b0; bus.A = 32'hAAAAAA48; bus.TT = 5'b00010; bus.TBST = 1'b1;
        @(negedge CLK);
        bus.TS = 1'b1;
        chk("b2b_bg_released", 64'(bus.BG), 64'(1));
        @(negedge CLK);
        chk("b2b_dbg", 64'(bus.DBG), 64'(0));
        @(negedge CLK);
        chk("b2b_ta", 64'(bus.TA), 64'(0));
        bus.DH_IN = 32'h99; bus.DL_IN = 32'h98;
        @(negedge CLK);
        chk("b2b_idle_bg", 64'(bus.BG), 64'(1));
        @(negedge CLK);
        chk("b2b_regrant", 64'(bus.BG), 64'(0));
        model_commit(32'hAAAAAA48, 5'b00010, 1'b1, 1'b0, {192'd0, 64'h0000009900000098});
        bus.BR = 1'b1; bus.TS = 1'b0; bus.TT = 5'b00000;
        @(negedge CLK);
        bus.TS = 1'b1;
        chk("b2b_addr_only_aack", 64'(bus.AACK), 64'(0));
        @(negedge CLK);

        // Reset during the third beat of a burst write
        bus.BR = 1'b0;
        wait_grant(lat);
        bus.BR = 1'b1; bus.TS = 1'b0; bus.A = 32'hAAAAAA00; bus.TT = 5'b00110; bus.TBST = 1'b0;
        @(negedge CLK);
        bus.TS = 1'b1;
        @(negedge CLK);
        for (int b = 0; b < 3; b++) begin
            @(negedge CLK);
            chk($sformatf("mid_rst_ta%0d", b), 64'(bus.TA), 64'(0));
            bus.DH_IN = '0;
            bus.DL_IN = 32'(16 + b);
        end
        RST = 1'b1;
        #1;
        chk("mid_rst_bg", 64'(bus.BG), 64'(1));
        chk("mid_rst_aack", 64'(bus.AACK), 64'(1));
        chk("mid_rst_artry", 64'(bus.ARTRY), 64'(1));
        chk("mid_rst_dbg", 64'(bus.DBG), 64'(1));
        chk("mid_rst_ta", 64'(bus.TA), 64'(1));
        chk("mid_rst_tea", 64'(bus.TEA), 64'(1));
        chk("mid_rst_doe", 64'(bus.D_OE), 64'(0));
        chk("mid_rst_dout", 64'({bus.DH_OUT, bus.DL_OUT}), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        bus.DL_IN = '0;
        mdl[0] = 64'd16; known[0] = 1'b1;
        mdl[1] = 64'd17; known[1] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            run_txn(32'hAAAAAA00 + 32'(8 * b), 5'b01010, 1'b1, 1'b0, '0,
                    bg_lat, aack_n, artry_n, dbg_at, ta_n, ta_at, tea_n, doe_n, rd);
            chk_common($sformatf("post_rst%0d", b), bg_lat, aack_n, ta_n, ta_at);
            chk($sformatf("post_rst%0d_ta", b), 64'(ta_n), 64'(1));
            chk($sformatf("post_rst%0d_rd", b), rd[0], 64'(16 + b));
        end

        // Randomized traffic against the memory model
        for (int t = 0; t < 60; t++) begin
            logic [31:0] addr;
            logic [4:0]  tt;
            logic        tbst, lock;
            logic [3:0][63:0] wd;
            bit inr, data, retry;
            int beats, e_ta, e_tea, e_doe;
            int pick;
            pick = $urandom_range(0, 4);
            case (pick)
                0: tt = 5'b00010;
                1: tt = 5'b00110;
                2: tt = 5'b01010;
                3: tt = 5'b01110;
                default: tt = 5'($urandom);
            endcase
            addr = ($urandom_range(0, 6) == 0) ? $urandom : {24'hAAAAAA, 8'($urandom)};
            tbst = 1'($urandom);
            lock = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 4; b++) wd[b] = {$urandom, $urandom};

            inr   = (addr[31:8] == 24'hAAAAAA);
            beats = tbst ? 1 : 4;
            retry = RETRY_EN && lock;
            data  = (tt_wr(tt) || tt_rd(tt)) && !retry;
            e_ta  = (data && inr) ? beats : 0;
            e_tea = (data && !inr) ? 1 : 0;
            e_doe = (data && inr && tt_rd(tt)) ? beats : 0;

            run_txn(addr, tt, tbst, lock, wd,
                    bg_lat, aack_n, artry_n, dbg_at, ta_n, ta_at, tea_n, doe_n, rd);
            chk_common($sformatf("rnd%0d", t), bg_lat, aack_n, ta_n, ta_at);
            chk($sformatf("rnd%0d_ta", t), 64'(ta_n), 64'(e_ta));
            chk($sformatf("rnd%0d_tea", t), 64'(tea_n), 64'(e_tea));
            chk($sformatf("rnd%0d_doe", t), 64'(doe_n), 64'(e_doe));
            chk($sformatf("rnd%0d_dbg_at", t), 64'(dbg_at), 64'(data ? 1 : -1));
            chk($sformatf("rnd%0d_artry", t), 64'(artry_n), 64'(retry ? 1 : 0));
            for (int b = 0; b < e_doe; b++)
                if (known[idx_of(addr, b)])
                    chk($sformatf("rnd%0d_rd%0d", t, b), rd[b], mdl[idx_of(addr, b)]);
            model_commit(addr, tt, tbst, lock, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
